// File: rtl/spi_reg_pkg.sv
// Shared constants and FSM state type for the SPI register peripheral.
package spi_reg_pkg;

  localparam int FRAME_BITS = 16;

  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-stage synchronizer for one asynchronous pin, with single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 responder writing five 8-bit PWM configuration registers.
// Optional register readback on cipo is built when SPI_READBACK_EN is defined.
//
// state  | meaning
// IDLE   | waiting for chip select to fall
// SHIFT  | shifting copi in on each sclk rising edge
// COMMIT | one cycle: load the addressed register if the frame is valid
module spi_reg_peripheral
  import spi_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  localparam logic [6:0] MAX_A = 7'(MAX_ADDR);
  localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_OVF  = 5'(FRAME_BITS + 1);

  logic sclk_q, sclk_rise, sclk_fall;
  logic copi_q, copi_rise, copi_fall;
  logic ncs_q, ncs_rise, ncs_fall;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .d(copi), .q(copi_q), .rise(copi_rise), .fall(copi_fall)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .d(ncs), .q(ncs_q), .rise(ncs_rise), .fall(ncs_fall)
  );

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] shreg_next;
  logic [4:0]            count;
  logic                  start, shift_en, commit_en;
  logic [6:0]            frame_addr;

  assign start      = (state_q == IDLE) && ncs_fall;
  assign shift_en   = (state_q == SHIFT) && sclk_rise && !ncs_q;
  assign shreg_next = {shreg[FRAME_BITS-2:0], copi_q};
  assign frame_addr = shreg[14:8];
  assign commit_en  = (state_q == COMMIT) && (count == CNT_FULL) && shreg[15]
                      && (frame_addr <= MAX_A);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ncs_fall) state_d = SHIFT;
      SHIFT:   if (ncs_rise) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Count saturates one past a full frame so long frames stay distinguishable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      count <= '0;
    end else if (start) begin
      shreg <= '0;
      count <= '0;
    end else if (shift_en) begin
      shreg <= shreg_next;
      if (count != CNT_OVF) count <= count + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
    end else if (commit_en) begin
      case (frame_addr)
        ADDR_EN_OUT_7_0:  en_reg_out_7_0  <= shreg[7:0];
        ADDR_EN_OUT_15_8: en_reg_out_15_8 <= shreg[7:0];
        ADDR_EN_PWM_7_0:  en_reg_pwm_7_0  <= shreg[7:0];
        ADDR_EN_PWM_15_8: en_reg_pwm_15_8 <= shreg[7:0];
        ADDR_PWM_DUTY:    pwm_duty_cycle  <= shreg[7:0];
        default: ;
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  logic [7:0] rd_data;
  logic [7:0] rd_mux;
  logic       unused_ok;

  assign unused_ok = &{1'b0, copi_rise, copi_fall, sclk_q};

  // Header is complete on the 8th rising edge: shreg_next[7] is R/W, [6:0] the address.
  always_comb begin
    rd_mux = 8'h00;
    if (shreg_next[6:0] <= MAX_A) begin
      case (shreg_next[6:0])
        ADDR_EN_OUT_7_0:  rd_mux = en_reg_out_7_0;
        ADDR_EN_OUT_15_8: rd_mux = en_reg_out_15_8;
        ADDR_EN_PWM_7_0:  rd_mux = en_reg_pwm_7_0;
        ADDR_EN_PWM_15_8: rd_mux = en_reg_pwm_15_8;
        ADDR_PWM_DUTY:    rd_mux = pwm_duty_cycle;
        default:          rd_mux = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
      cipo    <= 1'b0;
    end else if (state_q != SHIFT || ncs_q) begin
      rd_data <= '0;
      cipo    <= 1'b0;
    end else if (shift_en && count == 5'd7) begin
      rd_data <= shreg_next[7] ? 8'h00 : rd_mux;
    end else if (sclk_fall && count >= 5'd8 && count < CNT_FULL) begin
      cipo    <= rd_data[7];
      rd_data <= {rd_data[6:0], 1'b0};
    end
  end
`else
  logic unused_ok;

  assign unused_ok = &{1'b0, copi_rise, copi_fall, sclk_q, sclk_fall};
  assign cipo      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Self-checking bench for spi_reg_peripheral against an array-based register model.
module tb_spi_reg_peripheral;

  localparam int S     = 2;
  localparam int HALF  = 6;
  localparam int SETUP = 12;

  logic       clk = 1'b0;
  logic       rst_n, sclk, copi, ncs, cipo;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

  int total = 0;
  int bad   = 0;
  logic [7:0] model [5];

  spi_reg_peripheral #(.SYNC_STAGES(S), .MAX_ADDR(4)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] dut_reg(input int i);
    case (i)
      0: return en_reg_out_7_0;
      1: return en_reg_out_15_8;
      2: return en_reg_pwm_7_0;
      3: return en_reg_pwm_15_8;
      default: return pwm_duty_cycle;
    endcase
  endfunction

  // A frame writes only if it is exactly 16 bits, R/W=1 and address 0..4.
  function automatic void model_frame(input logic [31:0] word, input int n);
    if (n == 16 && word[15] && word[14:8] <= 7'd4) model[word[14:8]] = word[7:0];
  endfunction

  function automatic logic [7:0] expect_rx(input logic [31:0] word);
`ifdef SPI_READBACK_EN
    if (!word[15] && word[14:8] <= 7'd4) return model[word[14:8]];
    return 8'h00;
`else
    return 8'h00 & word[7:0];
`endif
  endfunction

  task automatic spi_xfer(input logic [31:0] word, input int nbits, input bit raise,
                          output logic [7:0] rx);
    logic [31:0] smp;
    smp = '0;
    ncs = 1'b0;
    repeat (SETUP) @(posedge clk); #3;
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = word[i];
      repeat (HALF) @(posedge clk); #3;
      smp  = {smp[30:0], cipo};
      sclk = 1'b1;
      repeat (HALF) @(posedge clk); #3;
      sclk = 1'b0;
    end
    rx = smp[7:0];
    if (raise) begin
      repeat (SETUP) @(posedge clk); #3;
      ncs = 1'b1;
    end
  endtask

  task automatic do_frame(input logic [31:0] word, input int n, output logic [7:0] rx);
    spi_xfer(word, n, 1'b1, rx);
    model_frame(word, n);
    repeat (S + 2) @(posedge clk); #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
    repeat (3) @(posedge clk); #3;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (dut_reg(i) !== 8'h00) begin
        bad++; $display("FAIL reset_reg%0d: got %h want 00", i, dut_reg(i));
      end
    end
    total++;
    if (cipo !== 1'b0) begin bad++; $display("FAIL reset_cipo: got %b want 0", cipo); end
  endtask

  task automatic test_basic_write();
    logic [7:0] rx;
    spi_xfer(32'h80F0, 16, 1'b1, rx);
    repeat (S + 1) @(posedge clk); #1;
    total++;
    if (en_reg_out_7_0 !== 8'h00) begin
      bad++; $display("FAIL latency_early_out: got %h want 00", en_reg_out_7_0);
    end
    @(posedge clk); #1;
    model_frame(32'h80F0, 16);
    total++;
    if (en_reg_out_7_0 !== 8'hF0) begin
      bad++; $display("FAIL latency_out_7_0: got %h want F0", en_reg_out_7_0);
    end
    spi_xfer(32'h8455, 16, 1'b1, rx);
    repeat (S + 1) @(posedge clk); #1;
    total++;
    if (pwm_duty_cycle !== 8'h00) begin
      bad++; $display("FAIL latency_early_duty: got %h want 00", pwm_duty_cycle);
    end
    @(posedge clk); #1;
    model_frame(32'h8455, 16);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (dut_reg(i) !== model[i]) begin
        bad++; $display("FAIL basic_reg%0d: got %h want %h", i, dut_reg(i), model[i]);
      end
    end
  endtask

  task automatic test_discard();
    logic [7:0] rx;
    reset_dut();
    do_frame(32'h8AAB, 16, rx);
    do_frame(32'h0133, 16, rx);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (dut_reg(i) !== model[i]) begin
        bad++; $display("FAIL discard_reg%0d: got %h want %h", i, dut_reg(i), model[i]);
      end
    end
  endtask

  task automatic test_length();
    logic [7:0] rx;
    do_frame(32'h0000_411E, 15, rx);
    total++;
    if (en_reg_pwm_7_0 !== model[2]) begin
      bad++; $display("FAIL short_frame: got %h want %h", en_reg_pwm_7_0, model[2]);
    end
    do_frame(32'h0001_0479, 17, rx);
    total++;
    if (en_reg_pwm_7_0 !== model[2]) begin
      bad++; $display("FAIL long_frame: got %h want %h", en_reg_pwm_7_0, model[2]);
    end
    do_frame(32'h823C, 16, rx);
    total++;
    if (en_reg_pwm_7_0 !== 8'h3C) begin
      bad++; $display("FAIL clean_after_bad_len: got %h want 3C", en_reg_pwm_7_0);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] rx;
    spi_xfer(32'h0000_020F, 10, 1'b0, rx);
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (dut_reg(i) !== model[i]) begin
        bad++; $display("FAIL midframe_rst_reg%0d: got %h want %h", i, dut_reg(i), model[i]);
      end
    end
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk); #3;
    ncs = 1'b1;
    repeat (S + 4) @(posedge clk); #1;
    do_frame(32'h8301, 16, rx);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (dut_reg(i) !== model[i]) begin
        bad++; $display("FAIL after_rst_reg%0d: got %h want %h", i, dut_reg(i), model[i]);
      end
    end
  endtask

  task automatic test_idle_sclk();
    for (int i = 0; i < 20; i++) begin
      copi = 1'($urandom_range(0, 1));
      repeat (HALF) @(posedge clk); #3 sclk = 1'b1;
      repeat (HALF) @(posedge clk); #3 sclk = 1'b0;
    end
    repeat (S + 2) @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (dut_reg(i) !== model[i]) begin
        bad++; $display("FAIL idle_sclk_reg%0d: got %h want %h", i, dut_reg(i), model[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rx;
    do_frame(32'h8111, 16, rx);
    total++;
    if (en_reg_out_15_8 !== 8'h11) begin
      bad++; $display("FAIL b2b_first: got %h want 11", en_reg_out_15_8);
    end
    do_frame(32'h8122, 16, rx);
    total++;
    if (en_reg_out_15_8 !== 8'h22) begin
      bad++; $display("FAIL b2b_second: got %h want 22", en_reg_out_15_8);
    end
  endtask

  task automatic test_readback();
    logic [7:0] rx, exp;
    do_frame(32'h83A5, 16, rx);
    exp = expect_rx(32'h0300);
    do_frame(32'h0300, 16, rx);
    total++;
    if (rx !== exp) begin bad++; $display("FAIL read_addr3: got %h want %h", rx, exp); end
    exp = expect_rx(32'h0700);
    do_frame(32'h0700, 16, rx);
    total++;
    if (rx !== exp) begin bad++; $display("FAIL read_addr7: got %h want %h", rx, exp); end
    total++;
    if (en_reg_pwm_15_8 !== 8'hA5) begin
      bad++; $display("FAIL read_no_alter: got %h want A5", en_reg_pwm_15_8);
    end
    total++;
    if (cipo !== 1'b0) begin bad++; $display("FAIL cipo_idle: got %b want 0", cipo); end
  endtask

  task automatic test_random();
    logic [7:0]  rx, exp;
    logic [31:0] word;
    int          n, pick;
    reset_dut();
    for (int k = 0; k < 40; k++) begin
      word = {16'h0, 1'($urandom_range(0, 3) != 0), 7'($urandom_range(0, 7)), 8'($urandom)};
      pick = $urandom_range(0, 5);
      n = (pick == 0) ? 15 : (pick == 1) ? 17 : 16;
      exp = expect_rx(word);
      if (n == 15) word = word >> 1;
      if (n == 17) word = {word[30:0], 1'($urandom_range(0, 1))};
      do_frame(word, n, rx);
      if (n == 16) begin
        total++;
        if (rx !== exp) begin
          bad++; $display("FAIL rand_rx[%0d]: word %h got %h want %h", k, word, rx, exp);
        end
      end
      for (int i = 0; i < 5; i++) begin
        total++;
        if (dut_reg(i) !== model[i]) begin
          bad++; $display("FAIL rand[%0d]_reg%0d: got %h want %h", k, i, dut_reg(i), model[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_discard();
    test_length();
    test_reset_midframe();
    test_idle_sclk();
    test_back_to_back();
    test_readback();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_reg_peripheral.md
Name: spi_reg_peripheral

Overview:
- SPI mode-0 responder that decodes 16-bit write frames from an external controller into the five PWM configuration registers.
- Drives en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8 and pwm_duty_cycle, which the top level passes to pwm_peripheral.
- Sits in the top level. SPI pins come from ui_in[0] (copi), ui_in[1] (ncs) and ui_in[2] (sclk). All pins are asynchronous to clk.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronizer on sclk, copi and ncs (minimum 2).
- MAX_ADDR, 4, highest valid register address; writes to any address above it are discarded.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- sclk  in  1  SPI clock, asynchronous to clk.
- copi  in  1  SPI controller-out data, asynchronous to clk.
- ncs  in  1  SPI chip select, active-low, asynchronous to clk.
- cipo  out  1  SPI read data; held 0 unless SPI_READBACK_EN is defined.
- en_reg_out_7_0  out  8  register 0x00.
- en_reg_out_15_8  out  8  register 0x01.
- en_reg_pwm_7_0  out  8  register 0x02.
- en_reg_pwm_15_8  out  8  register 0x03.
- pwm_duty_cycle  out  8  register 0x04.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. Reset drives all five registers to 0x00, cipo to 0, synchronizers to idle (ncs=1, sclk=0), bit counter to 0, FSM to IDLE.
- Frame format: 16 bits, MSB first, copi sampled on each synced sclk rising edge.
  - bit15 = R/W (1 = write).
  - bits14:8 = address.
  - bits7:0 = data.
- Timing requirement: sclk high and low phases each ≥ SYNC_STAGES+2 clk periods; ncs setup/hold ≥ one sclk period.
- Edge detection: compares the last synced sample with the previous one. It is active only while synced ncs = 0.
- FSM:
  - IDLE -> SHIFT on synced ncs falling edge. Clears the shift register and bit counter.
  - SHIFT: each sclk rising edge shifts in copi. The counter counts to 17 and saturates there; a count of 17 marks overflow.
  - SHIFT -> COMMIT on synced ncs rising edge.
  - COMMIT -> IDLE after exactly one cycle.
- Commit rule: the addressed register loads data in COMMIT only if all of the following hold: count == 16, bit15 == 1, address ≤ MAX_ADDR. Otherwise nothing changes.
- Latency: the register is visible SYNC_STAGES+2 clk cycles after the ncs pin rises.
- Boundaries:
  - Short frame (<16 bits): discarded.
  - Long frame (>16 bits): discarded.
  - Address > MAX_ADDR: discarded.
  - bit15 = 0: no write.
  - ncs glitch with no sclk edges: count 0, discarded.
  - rst_n asserted mid-frame: frame aborted, registers 0.
  - sclk edges while ncs is high: ignored.
- Registers hold their value indefinitely between commits. Back-to-back frames are legal once ncs has been high for ≥ SYNC_STAGES+2 clk cycles.

Optional Feature:
- Macro: SPI_READBACK_EN.
- Defined:
  - A frame with bit15 = 0 is a read.
  - After the 8th rising edge, cipo drives data bit7 of the addressed register on the next synced sclk falling edge, then bits 6..0 on the following falling edges.
  - Invalid address returns 0x00.
  - cipo = 0 whenever ncs is high or the frame is a write.
  - Register state is never altered by a read.
- Undefined: cipo is constant 0 and read frames are discarded. No read-mux logic is built.

Decomposition:
- Package spi_reg_pkg holds:
  - Address constants ADDR_EN_OUT_7_0=7'h00, ADDR_EN_OUT_15_8=7'h01, ADDR_EN_PWM_7_0=7'h02, ADDR_EN_PWM_15_8=7'h03, ADDR_PWM_DUTY=7'h04.
  - FRAME_BITS=16.
  - FSM state enum {IDLE, SHIFT, COMMIT}.
- Sub-module spi_sync: SYNC_STAGES-deep synchronizer with rise/fall pulse outputs and a reset-value parameter. Instantiated three times (sclk, copi, ncs).

Test Plan:
- Write frame 0x80F0, then 0x8455 -> en_reg_out_7_0 = 0xF0, pwm_duty_cycle = 0x55; the other registers stay 0x00, and each value is visible SYNC_STAGES+2 cycles after ncs rises.
- Write 0x8AAB (address 0x0A) and 0x0133 (R/W = 0) -> no register changes from the reset value.
- 15-bit frame, then 17-bit frame, each carrying write addr 0x02 data 0x3C -> en_reg_pwm_7_0 stays 0x00. A following clean 16-bit frame 0x823C -> 0x3C.
- rst_n pulsed low after 10 bits of 0x83FF -> all outputs 0x00. A following 0x8301 -> en_reg_pwm_15_8 = 0x01.
- Two back-to-back frames 0x8111 / 0x8122 at minimum ncs-high gap -> en_reg_out_15_8 = 0x22 and no lost or merged frame.
- SPI_READBACK_EN: write 0x83A5, then read frame 0x0300 -> cipo bits sampled on sclk rising edges = 0xA5. Read of address 0x07 -> 0x00. Without the macro -> cipo constantly 0.
